uart_rx_phy: RTL

UART_RX_PHY -- requirements
Module: uart_rx_phy

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_rx_phy.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Optional build macro: UART_RX_PARITY_EN adds the even-parity state.
package uart_pkg;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned DATA_BITS  = 8;

   localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W = $clog2(DATA_BITS);

   // Oversample counter values at the 8th (mid-bit) and 16th (next mid-bit) tick
   localparam logic [OS_W-1:0]  OS_MID   = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      ST_PARITY    = 3'd5
`endif
   } rx_state_e;

   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every DIV clocks, held at zero by clear.
module uart_baud_tick #(
   parameter int unsigned DIV = 54
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_cnt <= '0;
         tick  <= 1'b0;
      end else if (r_cnt == CNT_LAST) begin
         r_cnt <= '0;
         tick  <= 1'b1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_phy.sv
// 8N1 UART receiver with 16x oversampling and mid-bit sampling.
// Optional build macro: UART_RX_PARITY_EN (even parity bit plus parity_err output).
module uart_rx_phy
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 115_200
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_ready,
   output logic                 frame_err,
   output logic                 busy
`ifdef UART_RX_PARITY_EN
   ,
   output logic                 parity_err
`endif
);

   localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

   logic [1:0]           r_sync;
   logic                 w_rx;
   rx_state_e            r_state;
   rx_state_e            w_state_nxt;
   logic [OS_W-1:0]      r_os_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;

   logic w_tick;
   logic w_clear;
   logic w_mid_smp;
   logic w_bit_smp;
   logic w_os_restart;
   logic w_shift_en;
   logic w_ready_nxt;
   logic w_ferr_nxt;
   logic w_busy_nxt;
`ifdef UART_RX_PARITY_EN
   logic r_par_bit;
   logic w_par_en;
   logic w_perr_nxt;
`endif

   assign w_rx      = r_sync[1];
   assign w_mid_smp = w_tick && (r_os_cnt == OS_MID);
   assign w_bit_smp = w_tick && (r_os_cnt == OS_LAST);

   uart_baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk   (clk),
      .reset (reset),
      .clear (w_clear),
      .tick  (w_tick)
   );

   // Two-flop synchronizer; resets to the idle line level
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], rx};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_rx) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (w_mid_smp) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (w_bit_smp && (r_bit_cnt == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
               w_state_nxt = ST_PARITY;
`else
               w_state_nxt = ST_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (w_bit_smp) w_state_nxt = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (w_bit_smp) w_state_nxt = w_rx ? ST_IDLE : ST_WAIT_IDLE;
         end
         ST_WAIT_IDLE: begin
            if (w_rx) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Datapath controls and next values of the registered outputs
   always_comb begin
      w_clear      = 1'b0;
      w_os_restart = 1'b0;
      w_shift_en   = 1'b0;
      w_ready_nxt  = 1'b0;
      w_ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_en     = 1'b0;
      w_perr_nxt   = 1'b0;
`endif
      w_busy_nxt   = (w_state_nxt != ST_IDLE);
      case (r_state)
         ST_IDLE, ST_WAIT_IDLE: w_clear = 1'b1;
         ST_START:              w_os_restart = w_mid_smp;
         ST_DATA:               w_shift_en = w_bit_smp;
`ifdef UART_RX_PARITY_EN
         ST_PARITY:             w_par_en = w_bit_smp;
`endif
         ST_STOP: begin
            if (w_bit_smp) begin
               if (!w_rx) w_ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
               else if (even_parity(r_shift) != r_par_bit) w_perr_nxt = 1'b1;
`endif
               else w_ready_nxt = 1'b1;
            end
         end
         default: w_clear = 1'b1;
      endcase
   end

   // The start mid-sample realigns the oversample count so later samples land mid-bit
   always_ff @(posedge clk) begin
      if (reset) begin
         r_os_cnt  <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
      end else begin
         if (w_clear || w_os_restart) begin
            r_os_cnt <= '0;
         end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + OS_W'(1);
         end
         if (w_clear) begin
            r_bit_cnt <= '0;
         end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
         end
         if (w_shift_en) begin
            r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_data   <= '0;
         rx_ready  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         rx_ready  <= w_ready_nxt;
         frame_err <= w_ferr_nxt;
         busy      <= w_busy_nxt;
         if (w_ready_nxt) rx_data <= r_shift;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_par_bit  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= w_perr_nxt;
         if (w_par_en) r_par_bit <= w_rx;
      end
   end
`endif

endmodule
